mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shared-memory arbiter: one bus master port serving fetch and load/store.
// Load/store wins contention; a RESP turnaround cycle follows every transfer.
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  input  logic        flush,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        stallreq_from_if,
  output logic        stallreq_from_mem,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE, BUS_IF, BUS_MEM, RESP
  } state_e;

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        drop_q, drop_d;
  logic        err_q, err_d;
  logic        resp_if_q, resp_if_d;
  logic        drop_now;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      sel_q       <= 4'h0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      if_rdata_q  <= 32'h0;
      mem_rdata_q <= 32'h0;
      cnt_q       <= 8'h0;
      drop_q      <= 1'b0;
      err_q       <= 1'b0;
      resp_if_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      cnt_q       <= cnt_d;
      drop_q      <= drop_d;
      err_q       <= err_d;
      resp_if_q   <= resp_if_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    cnt_d       = cnt_q;
    drop_d      = drop_q;
    err_d       = err_q;
    resp_if_d   = resp_if_q;
    drop_now    = drop_q | flush;
    unique case (state_q)
      IDLE: begin
        if (mem_req) begin
          we_d      = mem_we;
          sel_d     = mem_sel;
          addr_d    = mem_addr;
          wdata_d   = mem_wdata;
          cnt_d     = 8'h0;
          resp_if_d = 1'b0;
          state_d   = BUS_MEM;
        end else if (if_req) begin
          we_d      = 1'b0;
          sel_d     = 4'b1111;
          addr_d    = if_addr;
          cnt_d     = 8'h0;
          resp_if_d = 1'b1;
          drop_d    = flush;
          state_d   = BUS_IF;
        end
      end
      BUS_IF: begin
        drop_d = drop_now;
        // A dropped fetch still finishes on the bus but leaves if_rdata alone
        if (bus_ack) begin
          if (!drop_now) if_rdata_d = bus_rdata;
          state_d = RESP;
        end else if (cnt_q == LIMIT) begin
          if (!drop_now) if_rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      BUS_MEM: begin
        if (bus_ack) begin
          mem_rdata_d = bus_rdata;
          state_d     = RESP;
        end else if (cnt_q == LIMIT) begin
          mem_rdata_d = 32'h0;
          err_d       = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        drop_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_req   = (state_q == BUS_IF) || (state_q == BUS_MEM);
  assign bus_we    = we_q;
  assign bus_sel   = sel_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_err   = err_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_ack    = (state_q == RESP) && resp_if_q && !drop_q;
  assign mem_ack   = (state_q == RESP) && !resp_if_q;

  assign stallreq_from_if  = if_req & ~if_ack;
  assign stallreq_from_mem = mem_req & ~mem_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, contention, flush, timeout,
// reset mid-transfer and back-to-back fetches.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [3:0]  mem_sel = 4'h0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        flush = 1'b0;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_ack = 1'b0;
  logic        stallreq_from_if;
  logic        stallreq_from_mem;
  logic        bus_err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .flush(flush),
    .bus_req(bus_req), .bus_we(bus_we),
    .bus_sel(bus_sel), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack),
    .stallreq_from_if(stallreq_from_if),
    .stallreq_from_mem(stallreq_from_mem),
    .bus_err(bus_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int acks;
    int last;
    int gap_bad;

    #2;
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_if_ack", 32'(if_ack), 32'd0);
    chk("rst_mem_ack", 32'(mem_ack), 32'd0);
    chk("rst_err", 32'(bus_err), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    #20 rst = 1'b1;
    step();

    // single fetch
    if_req  = 1'b1;
    if_addr = 32'h0000_0100;
    #1;
    chk("f_stall", 32'(stallreq_from_if), 32'd1);
    step();
    chk("f_bus_req", 32'(bus_req), 32'd1);
    chk("f_addr", bus_addr, 32'h0000_0100);
    chk("f_we", 32'(bus_we), 32'd0);
    chk("f_sel", 32'(bus_sel), 32'hF);
    chk("f_ack_early", 32'(if_ack), 32'd0);
    chk("f_stall2", 32'(stallreq_from_if), 32'd1);
    bus_ack   = 1'b1;
    bus_rdata = 32'h2402_0005;
    step();
    chk("f_ack", 32'(if_ack), 32'd1);
    chk("f_rdata", if_rdata, 32'h2402_0005);
    chk("f_stall_rel", 32'(stallreq_from_if), 32'd0);
    chk("f_resp_req", 32'(bus_req), 32'd0);
    bus_ack = 1'b0;
    if_req  = 1'b0;
    step();
    chk("f_ack_once", 32'(if_ack), 32'd0);

    // contention: mem first, then fetch
    if_req    = 1'b1;
    if_addr   = 32'h0000_0200;
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    mem_addr  = 32'h0000_0080;
    mem_wdata = 32'hDEAD_BEEF;
    mem_sel   = 4'b1111;
    step();
    chk("c_req", 32'(bus_req), 32'd1);
    chk("c_we", 32'(bus_we), 32'd1);
    chk("c_addr", bus_addr, 32'h0000_0080);
    chk("c_wdata", bus_wdata, 32'hDEAD_BEEF);
    chk("c_stall_m", 32'(stallreq_from_mem), 32'd1);
    bus_ack   = 1'b1;
    bus_rdata = 32'h1111_2222;
    step();
    chk("c_mem_ack", 32'(mem_ack), 32'd1);
    chk("c_mem_rdata", mem_rdata, 32'h1111_2222);
    chk("c_if_ack", 32'(if_ack), 32'd0);
    chk("c_if_rdata", if_rdata, 32'h2402_0005);
    chk("c_resp_req", 32'(bus_req), 32'd0);
    mem_req = 1'b0;
    bus_ack = 1'b0;
    step();
    chk("c_idle_req", 32'(bus_req), 32'd0);
    step();
    chk("c_if_grant", 32'(bus_req), 32'd1);
    chk("c_if_addr", bus_addr, 32'h0000_0200);
    chk("c_if_we", 32'(bus_we), 32'd0);
    bus_ack   = 1'b1;
    bus_rdata = 32'h3333_4444;
    step();
    chk("c_if_ack2", 32'(if_ack), 32'd1);
    chk("c_if_rdata2", if_rdata, 32'h3333_4444);
    chk("c_mem_rd_hold", mem_rdata, 32'h1111_2222);
    if_req  = 1'b0;
    bus_ack = 1'b0;
    step();

    // flush during BUS_IF
    if_req  = 1'b1;
    if_addr = 32'h0000_0300;
    step();
    chk("fl_grant", 32'(bus_req), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    acks = 0;
    repeat (2) begin
      if (if_ack) acks++;
      step();
    end
    chk("fl_held", 32'(bus_req), 32'd1);
    bus_ack   = 1'b1;
    bus_rdata = 32'h0BAD_0BAD;
    step();
    if (if_ack) acks++;
    chk("fl_no_ack", 32'(acks), 32'd0);
    chk("fl_done", 32'(bus_req), 32'd0);
    chk("fl_rdata", if_rdata, 32'h3333_4444);
    chk("fl_stall", 32'(stallreq_from_if), 32'd1);
    if_req  = 1'b0;
    bus_ack = 1'b0;
    step();
    chk("fl_idle_ack", 32'(if_ack), 32'd0);
    step();

    // ack on the last allowed cycle wins over timeout
    mem_req = 1'b1;
    mem_we  = 1'b0;
    mem_addr = 32'h0000_0400;
    step();
    mem_req = 1'b0;
    repeat (254) step();
    chk("tl_req255", 32'(bus_req), 32'd1);
    bus_ack   = 1'b1;
    bus_rdata = 32'h5555_6666;
    step();
    bus_ack = 1'b0;
    chk("tl_mem_ack", 32'(mem_ack), 32'd1);
    chk("tl_rdata", mem_rdata, 32'h5555_6666);
    chk("tl_no_err", 32'(bus_err), 32'd0);
    step();

    // timeout
    mem_req = 1'b1;
    step();
    mem_req = 1'b0;
    n = 0;
    while (bus_req === 1'b1 && n < 400) begin
      n++;
      step();
    end
    chk("to_cycles", 32'(n), 32'd255);
    chk("to_mem_ack", 32'(mem_ack), 32'd1);
    chk("to_rdata", mem_rdata, 32'h0);
    chk("to_err", 32'(bus_err), 32'd1);
    repeat (3) step();
    chk("to_err_sticky", 32'(bus_err), 32'd1);
    chk("to_idle", 32'(bus_req), 32'd0);

    // reset mid-transfer, held mem_req re-granted
    mem_req = 1'b1;
    step();
    chk("r_busy", 32'(bus_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("r_req", 32'(bus_req), 32'd0);
    chk("r_err", 32'(bus_err), 32'd0);
    chk("r_if_rdata", if_rdata, 32'h0);
    chk("r_bus_addr", bus_addr, 32'h0);
    #10 rst = 1'b1;
    #1;
    chk("r_no_early", 32'(bus_req), 32'd0);
    step();
    chk("r_regrant", 32'(bus_req), 32'd1);
    chk("r_addr", bus_addr, 32'h0000_0400);
    bus_ack   = 1'b1;
    bus_rdata = 32'h7777_8888;
    step();
    chk("r_ack", 32'(mem_ack), 32'd1);
    mem_req = 1'b0;
    bus_ack = 1'b0;
    step();

    // back-to-back fetches
    if_req  = 1'b1;
    if_addr = 32'h0000_0500;
    bus_ack = 1'b1;
    bus_rdata = 32'h9999_AAAA;
    acks = 0;
    last = 0;
    gap_bad = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (if_ack) begin
        if (acks > 0 && c - last != 3) gap_bad++;
        acks++;
        last = c;
      end
    end
    chk("b2b_count", 32'(acks), 32'd4);
    chk("b2b_gap", 32'(gap_bad), 32'd0);
    chk("b2b_rdata", if_rdata, 32'h9999_AAAA);
    if_req  = 1'b0;
    bus_ack = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
